// File: rtl/gb_host_arb.sv
// Two-requester round-robin arbiter sharing one ghostbus host port.
// One transaction in flight: accept in IDLE, strobe in ISSUE, optional WAIT for read data, respond in RESP.
module gb_host_arb #(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          r0_valid,
  output logic          r0_ready,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_rsp,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_valid,
  output logic          r1_ready,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_rsp,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] gb_addr,
  output logic [DW-1:0] gb_wdata,
  output logic          gb_we,
  output logic          gb_re,
  input  logic [DW-1:0] gb_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

  req_t   [1:0]         req;
  logic   [1:0]         vld, sel;
  state_t               state_q, state_d;
  logic                 last_q, last_d;
  req_t                 cur_q, cur_d;
  logic   [3:0]         cnt_q, cnt_d;
  logic                 gb_we_q, gb_we_d, gb_re_q, gb_re_d;
  logic   [1:0]         rsp_q, rsp_d;
  logic   [1:0][DW-1:0] rdata_q, rdata_d;

  assign req[0] = {r0_we, r0_addr, r0_wdata};
  assign req[1] = {r1_we, r1_addr, r1_wdata};
  assign vld    = {r1_valid, r0_valid};

  // On a tie the requester that did not win last time gets the grant.
  assign sel[0] = vld[0] & (~vld[1] | last_q);
  assign sel[1] = vld[1] & (~vld[0] | ~last_q);

  // Ready is gated by reset so nothing looks accepted while the block is held.
  assign {r1_ready, r0_ready} = (rst_n && state_q == IDLE) ? sel : 2'b00;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cur_d   = cur_q;
    cnt_d   = cnt_q;
    gb_we_d = 1'b0;
    gb_re_d = 1'b0;
    rsp_d   = '0;
    rdata_d = '0;
    case (state_q)
      IDLE: begin
        if (|sel) begin
          last_d  = sel[1];
          cur_d   = req[sel[1]];
          gb_we_d = req[sel[1]].we;
          gb_re_d = ~req[sel[1]].we;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cur_q.we) begin
          rsp_d[last_q] = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Counter hits zero exactly RD_LAT cycles after the read strobe cycle.
        if (cnt_q == 4'd0) begin
          rsp_d[last_q]   = 1'b1;
          rdata_d[last_q] = gb_rdata;
          state_d         = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cur_q   <= '0;
      cnt_q   <= '0;
      gb_we_q <= 1'b0;
      gb_re_q <= 1'b0;
      rsp_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      gb_we_q <= gb_we_d;
      gb_re_q <= gb_re_d;
      rsp_q   <= rsp_d;
      rdata_q <= rdata_d;
    end
  end

  assign gb_addr  = cur_q.addr;
  assign gb_wdata = cur_q.wdata;
  assign gb_we    = gb_we_q;
  assign gb_re    = gb_re_q;
  assign r0_rsp   = rsp_q[0];
  assign r1_rsp   = rsp_q[1];
  assign r0_rdata = rdata_q[0];
  assign r1_rdata = rdata_q[1];

endmodule

// File: tb/tb_gb_host_arb.sv
// Bench for gb_host_arb: one arbiter per read latency, a ghostbus memory model behind each,
// directed steps driving requester queues and a scoreboard of expected responses.
module tb_gb_host_arb;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int NI = 5;
  localparam int LATS [NI] = '{3, 4, 1, 2, 15};

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } req_t;

  typedef struct {
    logic          rq;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            acc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          v0 [NI];
  logic          v1 [NI];
  logic          we0, we1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          rdy0 [NI], rdy1 [NI], rsp0 [NI], rsp1 [NI], gwe [NI], gre [NI];
  logic [DW-1:0] rd0 [NI], rd1 [NI], gwdata [NI];
  logic [AW-1:0] gaddr [NI];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(int a);
    return 32'hC0DE0000 ^ (32'(a) * 32'h00010101);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [DW-1:0] mem [256];
    logic [DW-1:0] rdata_m;
    logic [DW-1:0] pd = '0;
    int            cd = 0;
    logic          pv = 1'b0;

    gb_host_arb #(.AW(AW), .DW(DW), .RD_LAT(LATS[g])) u_dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(v0[g]), .r0_ready(rdy0[g]), .r0_we(we0), .r0_addr(a0), .r0_wdata(d0),
      .r0_rsp(rsp0[g]), .r0_rdata(rd0[g]),
      .r1_valid(v1[g]), .r1_ready(rdy1[g]), .r1_we(we1), .r1_addr(a1), .r1_wdata(d1),
      .r1_rsp(rsp1[g]), .r1_rdata(rd1[g]),
      .gb_addr(gaddr[g]), .gb_wdata(gwdata[g]), .gb_we(gwe[g]), .gb_re(gre[g]),
      .gb_rdata(rdata_m)
    );

    initial for (int i = 0; i < 256; i++) mem[i] = init_val(i);

    // Read data is valid only in the cycle RD_LAT after the read strobe; other cycles carry its inverse.
    always @(posedge clk) begin
      if (gwe[g]) mem[gaddr[g][7:0]] = gwdata[g];
      if (gre[g]) begin
        pd = mem[gaddr[g][7:0]];
        cd = LATS[g] - 1;
        pv = 1'b1;
      end else if (pv) begin
        if (cd == 0) pv = 1'b0;
        else cd = cd - 1;
      end
      rdata_m <= (pv && cd == 0) ? pd : ~pd;
    end
  end

  int            vectors = 0;
  int            miscompares = 0;
  int            k = 0;
  int            cyc = 0;
  int            prev_acc = -1;
  int            rsp_cnt [2];
  bit            tput_chk = 1'b0;
  logic          last_g = 1'b1;
  req_t          pend0 [$];
  req_t          pend1 [$];
  exp_t          sb [$];
  logic [DW-1:0] ref_mem [NI][256];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (inst %0d, cycle %0d)", tag, obs, expv, k, cyc);
    end
  endtask

  task automatic push(int rq, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    req_t r;
    r.we = we; r.addr = a; r.data = d;
    if (rq == 0) pend0.push_back(r);
    else pend1.push_back(r);
  endtask

  // One clock: drive at posedge+1, sample and score at negedge, return at next posedge+1.
  task automatic cycle();
    exp_t          e;
    req_t          r;
    logic [DW-1:0] rdv;
    v0[k] = pend0.size() != 0;
    v1[k] = pend1.size() != 0;
    if (pend0.size() != 0) begin we0 = pend0[0].we; a0 = pend0[0].addr; d0 = pend0[0].data; end
    if (pend1.size() != 0) begin we1 = pend1[0].we; a1 = pend1[0].addr; d1 = pend1[0].data; end
    @(negedge clk);
    chk("ready_excl", 64'(rdy0[k] & rdy1[k]), 0);
    chk("ready_no_valid", {rdy0[k] & ~v0[k], rdy1[k] & ~v1[k]}, 0);
    chk("strobe_excl", 64'(gwe[k] & gre[k]), 0);
    if (gwe[k] || gre[k]) begin
      chk("strobe_inflight", sb.size(), 1);
      if (sb.size() != 0) begin
        chk("gb_we", gwe[k], sb[0].we);
        chk("gb_re", gre[k], !sb[0].we);
        chk("gb_addr", gaddr[k], sb[0].addr);
        if (sb[0].we) chk("gb_wdata", gwdata[k], sb[0].wdata);
        chk("strobe_lat", cyc - sb[0].acc, 1);
      end
    end
    chk("rsp_excl", 64'(rsp0[k] & rsp1[k]), 0);
    if (rsp0[k] || rsp1[k]) begin
      chk("rsp_pending", sb.size(), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        rsp_cnt[rsp1[k] ? 1 : 0]++;
        chk("rsp_id", rsp1[k], e.rq);
        rdv = rsp1[k] ? rd1[k] : rd0[k];
        chk("rsp_rdata", rdv, e.rdata);
        chk("rsp_lat", cyc - e.acc, e.we ? 2 : LATS[k] + 2);
      end
    end
    if ((v0[k] && rdy0[k]) || (v1[k] && rdy1[k])) begin
      e.rq = !(v0[k] && rdy0[k]);
      if (v0[k] && v1[k]) chk("rr_order", e.rq, !last_g);
      if (tput_chk && prev_acc >= 0) chk("acc_spacing", cyc - prev_acc, 3);
      prev_acc = cyc;
      last_g   = e.rq;
      r = e.rq ? pend1.pop_front() : pend0.pop_front();
      e.we = r.we; e.addr = r.addr; e.wdata = r.data; e.acc = cyc;
      e.rdata = r.we ? '0 : ref_mem[k][r.addr[7:0]];
      if (r.we) ref_mem[k][r.addr[7:0]] = r.data;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(int maxc);
    int n = 0;
    while ((pend0.size() != 0 || pend1.size() != 0 || sb.size() != 0) && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain_timeout", pend0.size() + pend1.size() + sb.size(), 0);
    repeat (3) cycle();
  endtask

  // Async assert mid-cycle with both valids high; outputs must be 0 at once.
  task automatic do_reset();
    v0[k] = 1'b1; v1[k] = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_r0_ready", rdy0[k], 0);
    chk("rst_r1_ready", rdy1[k], 0);
    chk("rst_r0_rsp", rsp0[k], 0);
    chk("rst_r1_rsp", rsp1[k], 0);
    chk("rst_r0_rdata", rd0[k], 0);
    chk("rst_r1_rdata", rd1[k], 0);
    chk("rst_gb_addr", gaddr[k], 0);
    chk("rst_gb_wdata", gwdata[k], 0);
    chk("rst_gb_we", gwe[k], 0);
    chk("rst_gb_re", gre[k], 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    v0[k] = 1'b0; v1[k] = 1'b0;
    @(posedge clk); #1;
    sb.delete(); pend0.delete(); pend1.delete();
    last_g = 1'b1; prev_acc = -1; rsp_cnt[0] = 0; rsp_cnt[1] = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    we0 = 1'b0; we1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int i = 0; i < NI; i++) begin
      v0[i] = 1'b0; v1[i] = 1'b0;
      for (int j = 0; j < 256; j++) ref_mem[i][j] = init_val(j);
    end
    rsp_cnt[0] = 0; rsp_cnt[1] = 0;
    @(posedge clk); #1;

    // RD_LAT=3 instance: single write, write then read, contention, hold stability
    k = 0;
    do_reset();
    push(0, 1'b1, 24'h000010, 32'hDEADBEEF);
    run(20);
    chk("single_wr_rsp_cnt", rsp_cnt[0] * 16 + rsp_cnt[1], 16);
    push(0, 1'b1, 24'h000020, 32'h12345678);
    run(20);
    push(1, 1'b0, 24'h000020, '0);
    run(30);

    do_reset();
    tput_chk = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b1, 24'h000100 + 24'(i), 32'hA0000000 + 32'(i));
      push(1, 1'b1, 24'h000200 + 24'(i), 32'hB0000000 + 32'(i));
    end
    run(60);
    tput_chk = 1'b0;
    chk("cont_rsp_cnt0", rsp_cnt[0], 4);
    chk("cont_rsp_cnt1", rsp_cnt[1], 4);

    push(0, 1'b1, 24'h000010, 32'hAAAA5555);
    push(0, 1'b1, 24'h000099, 32'h5555AAAA);
    run(30);

    // RD_LAT=4 instance: reset while waiting for read data
    k = 1;
    do_reset();
    push(1, 1'b0, 24'h000040, '0);
    repeat (3) cycle();
    chk("mid_read_inflight", sb.size(), 1);
    do_reset();
    repeat (10) cycle();
    push(0, 1'b1, 24'h000041, 32'h01010101);
    push(1, 1'b1, 24'h000042, 32'h02020202);
    run(30);
    chk("post_rst_rsp_cnt", rsp_cnt[0] * 16 + rsp_cnt[1], 17);

    // Random mixed traffic against the memory model at RD_LAT 1, 2, 15
    for (int i = 2; i < NI; i++) begin
      k = i;
      do_reset();
      for (int n = 0; n < 24; n++)
        push(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             {16'($urandom), 4'h0, 4'($urandom_range(0, 15))}, $urandom);
      run(3000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
